// File: rtl/tpseqsys_pio_poller_pkg.sv
// Shared types and constants for the switch PIO poller.
// Consumed by tpseqsys_pio_poller and tpseqsys_poll_timer via import tpseqsys_poller_pkg::*.
package tpseqsys_poller_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    REQ    = 2'd1,
    WAIT   = 2'd2,
    UPDATE = 2'd3
  } poll_state_e;

  localparam int POLL_DIV_DEF = 50000;
  localparam int POLL_CNT_W   = $clog2(POLL_DIV_DEF);
  // Wide enough to count a read latency of up to 4.
  localparam int LAT_W        = 3;

  function automatic int cnt_w(input int div);
    return (div > 1) ? $clog2(div) : 1;
  endfunction

endpackage

// File: rtl/tpseqsys_pio_poller_if.sv
// Avalon-MM read-only master/slave bundle between the poller and the switch PIO.
interface tpseqsys_pio_poller_if;
  logic [1:0]  avm_address;
  logic        avm_read;
  logic        avm_waitrequest;
  logic [31:0] avm_readdata;

  modport master (
    output avm_address,
    output avm_read,
    input  avm_waitrequest,
    input  avm_readdata
  );

  modport slave (
    input  avm_address,
    input  avm_read,
    output avm_waitrequest,
    output avm_readdata
  );
endinterface

// File: rtl/tpseqsys_poll_timer.sv
// Free-running poll period counter; tick is high on the last cycle of each period.
// Held at zero while polling is disabled.
module tpseqsys_poll_timer
  import tpseqsys_poller_pkg::*;
#(
  parameter int POLL_DIV = 50000
) (
  input  logic clk,
  input  logic reset_n,
  input  logic enable,
  output logic tick
);

  localparam int CW = cnt_w(POLL_DIV);

  logic [CW-1:0] cnt_q;
  logic          last;

  assign last = (cnt_q == CW'(POLL_DIV - 1));
  assign tick = enable && last;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q <= '0;
    end else if (!enable || last) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_q + CW'(1);
    end
  end

endmodule

// File: rtl/tpseqsys_pio_poller.sv
// Avalon-MM poller for the switch PIO: periodic reads, last value, per-bit rise/fall flags.
// Optional build macro TPSEQSYS_PIO_POLLER_DEBOUNCE_EN requires DEB_CNT identical samples before reporting.
module tpseqsys_pio_poller
  import tpseqsys_poller_pkg::*;
#(
  parameter int DATA_W   = 10,
  parameter int POLL_DIV = 50000,
  parameter int READ_LAT = 1,
  parameter int PIO_ADDR = 0,
  parameter int DEB_CNT  = 4
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  enable,
  tpseqsys_pio_poller_if.master avm,
  output logic [DATA_W-1:0]     sample_q,
  output logic                  change_p,
  output logic [DATA_W-1:0]     rise_mask,
  output logic [DATA_W-1:0]     fall_mask,
  output logic                  busy
);

  if (READ_LAT < 1 || READ_LAT > 4) begin : g_bad_lat
    $error("READ_LAT must be 1..4");
  end
  if (POLL_DIV < READ_LAT + 3) begin : g_bad_div
    $error("POLL_DIV too small for READ_LAT");
  end
  if (DEB_CNT < 2 || DEB_CNT > 15) begin : g_bad_deb
    $error("DEB_CNT must be 2..15");
  end

  poll_state_e       state_q;
  logic [LAT_W-1:0]  lat_q;
  logic [DATA_W-1:0] rd_q;
  logic              first_q;
  logic              read_q;
  logic              tick;
  logic              report;

  assign avm.avm_address = 2'(PIO_ADDR);
  assign avm.avm_read    = read_q;

  tpseqsys_poll_timer #(
    .POLL_DIV (POLL_DIV)
  ) u_timer (
    .clk     (clk),
    .reset_n (reset_n),
    .enable  (enable),
    .tick    (tick)
  );

`ifdef TPSEQSYS_PIO_POLLER_DEBOUNCE_EN
  logic [DATA_W-1:0] cand_q;
  logic [3:0]        stab_q;
  logic [3:0]        stab_next;

  function automatic logic [3:0] sat_inc(input logic [3:0] v);
    return (v >= 4'(DEB_CNT)) ? v : v + 4'd1;
  endfunction

  assign stab_next = (rd_q == cand_q) ? sat_inc(stab_q) : 4'd1;
  assign report    = (stab_next >= 4'(DEB_CNT));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cand_q <= '0;
      stab_q <= '0;
    end else if (state_q == UPDATE) begin
      cand_q <= rd_q;
      stab_q <= stab_next;
    end
  end
`else
  assign report = 1'b1;
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      lat_q     <= '0;
      rd_q      <= '0;
      first_q   <= 1'b1;
      read_q    <= 1'b0;
      sample_q  <= '0;
      change_p  <= 1'b0;
      rise_mask <= '0;
      fall_mask <= '0;
      busy      <= 1'b0;
    end else begin
      change_p <= 1'b0;
      case (state_q)
        // A tick arriving outside IDLE is dropped, so an overrun period is skipped.
        IDLE: begin
          if (tick) begin
            state_q <= REQ;
            read_q  <= 1'b1;
            busy    <= 1'b1;
          end
        end
        REQ: begin
          if (!avm.avm_waitrequest) begin
            state_q <= WAIT;
            read_q  <= 1'b0;
            lat_q   <= LAT_W'(1);
          end
        end
        WAIT: begin
          if (lat_q == LAT_W'(READ_LAT)) begin
            rd_q    <= avm.avm_readdata[DATA_W-1:0];
            state_q <= UPDATE;
          end else begin
            lat_q <= lat_q + LAT_W'(1);
          end
        end
        UPDATE: begin
          state_q <= IDLE;
          busy    <= 1'b0;
          if (report) begin
            if (first_q) begin
              sample_q <= rd_q;
              first_q  <= 1'b0;
            end else if (rd_q != sample_q) begin
              sample_q  <= rd_q;
              rise_mask <= rd_q & ~sample_q;
              fall_mask <= ~rd_q & sample_q;
              change_p  <= 1'b1;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule
